// File: rtl/apu_frame_counter_pkg.sv
// Shared constants and types for the APU frame sequencer.
// Step counts are CPU-cycle indices within one frame-sequencer period.
package apu_pkg;

  localparam logic [15:0] FC_STEP1 = 16'd7457;
  localparam logic [15:0] FC_STEP2 = 16'd14913;
  localparam logic [15:0] FC_STEP3 = 16'd22371;
  localparam logic [15:0] FC_IRQ0  = 16'd29828;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } fc_wr_state_t;

endpackage

// File: rtl/apu_frame_counter_if.sv
// CPU-side strobes into the frame sequencer and its pulse/IRQ outputs.
// The slave modport is the sequencer; the master modport is the APU/CPU glue.
interface apu_frame_counter_if;

  logic       cpu_ce;
  logic       reg_wren;
  logic [1:0] from_cpu;
  logic       status_rd;
  logic       q_pulse;
  logic       l_pulse;
  logic       frame_irq;

  modport master (
    output cpu_ce, reg_wren, from_cpu, status_rd,
    input  q_pulse, l_pulse, frame_irq
  );

  modport slave (
    input  cpu_ce, reg_wren, from_cpu, status_rd,
    output q_pulse, l_pulse, frame_irq
  );

endinterface

// File: rtl/apu_frame_decode.sv
// Combinational step decode of the frame counter value and mode.
// Zero latency; wrap_o marks the last count of the active mode.
module apu_frame_decode
  import apu_pkg::*;
#(
  parameter logic [15:0] P4_LAST = 16'd29829,
  parameter logic [15:0] P5_LAST = 16'd37281
) (
  input  logic [15:0] count_i,
  input  logic        mode_i,
  output logic        q_o,
  output logic        l_o,
  output logic        irq_o,
  output logic        wrap_o
);

  always_comb begin
    q_o    = 1'b0;
    l_o    = 1'b0;
    irq_o  = 1'b0;
    wrap_o = 1'b0;
    if (count_i == FC_STEP1 || count_i == FC_STEP3) begin
      q_o = 1'b1;
    end
    if (count_i == FC_STEP2) begin
      q_o = 1'b1;
      l_o = 1'b1;
    end
    if (!mode_i) begin
      if (count_i == FC_IRQ0) begin
        irq_o = 1'b1;
      end
      if (count_i == P4_LAST) begin
        q_o    = 1'b1;
        l_o    = 1'b1;
        irq_o  = 1'b1;
        wrap_o = 1'b1;
      end
    end else if (count_i == P5_LAST) begin
      q_o    = 1'b1;
      l_o    = 1'b1;
      wrap_o = 1'b1;
    end
  end

endmodule

// File: rtl/apu_frame_counter.sv
// APU frame sequencer: quarter/half-frame pulses and frame IRQ flag, driven by $4017 writes.
// Pulses and IRQ flag are registered (one clk after the deciding cpu_ce edge).
module apu_frame_counter
  import apu_pkg::*;
#(
  parameter logic [15:0] P4_LAST = 16'd29829,
  parameter logic [15:0] P5_LAST = 16'd37281
) (
  input  logic                clk,
  input  logic                rst_n,
  apu_frame_counter_if.slave  fc
);

  logic [15:0]  count_q, count_d;
  logic         mode_q, mode_d;
  logic         inhibit_q, inhibit_d;
  logic         irq_q, irq_d;
  logic         phase_q, phase_d;
  logic         pend_q, pend_d;
  logic [2:0]   dly_q, dly_d;
  fc_wr_state_t wr_st_q, wr_st_d;
  logic         q_q, q_d;
  logic         l_q, l_d;

  logic dec_q, dec_l, dec_irq, dec_wrap;
  logic expire;

  apu_frame_decode #(
    .P4_LAST (P4_LAST),
    .P5_LAST (P5_LAST)
  ) u_decode (
    .count_i (count_q),
    .mode_i  (mode_q),
    .q_o     (dec_q),
    .l_o     (dec_l),
    .irq_o   (dec_irq),
    .wrap_o  (dec_wrap)
  );

  // A fresh write on the expiry cycle discards the old pending mode and restarts the delay.
  assign expire = fc.cpu_ce && (wr_st_q == WAIT) && (dly_q == 3'd1) && !fc.reg_wren;

  always_comb begin
    count_d   = count_q;
    mode_d    = mode_q;
    inhibit_d = inhibit_q;
    irq_d     = irq_q;
    phase_d   = phase_q;
    pend_d    = pend_q;
    dly_d     = dly_q;
    wr_st_d   = wr_st_q;
    q_d       = 1'b0;
    l_d       = 1'b0;

    if (fc.status_rd) begin
      irq_d = 1'b0;
    end

    if (fc.cpu_ce) begin
      phase_d = ~phase_q;
      if (expire) begin
        count_d = '0;
        mode_d  = pend_q;
        q_d     = pend_q;
        l_d     = pend_q;
        dly_d   = '0;
        wr_st_d = IDLE;
      end else begin
        count_d = dec_wrap ? '0 : count_q + 16'd1;
        q_d     = dec_q;
        l_d     = dec_l;
        if (dec_irq && !inhibit_q) begin
          irq_d = 1'b1;
        end
        if (wr_st_q == WAIT) begin
          dly_d = dly_q - 3'd1;
        end
      end
    end

    if (fc.reg_wren) begin
      inhibit_d = fc.from_cpu[0];
      pend_d    = fc.from_cpu[1];
      dly_d     = phase_q ? 3'd3 : 3'd4;
      wr_st_d   = WAIT;
      if (fc.from_cpu[0]) begin
        irq_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      mode_q    <= 1'b0;
      inhibit_q <= 1'b0;
      irq_q     <= 1'b0;
      phase_q   <= 1'b0;
      pend_q    <= 1'b0;
      dly_q     <= '0;
      wr_st_q   <= IDLE;
      q_q       <= 1'b0;
      l_q       <= 1'b0;
    end else begin
      count_q   <= count_d;
      mode_q    <= mode_d;
      inhibit_q <= inhibit_d;
      irq_q     <= irq_d;
      phase_q   <= phase_d;
      pend_q    <= pend_d;
      dly_q     <= dly_d;
      wr_st_q   <= wr_st_d;
      q_q       <= q_d;
      l_q       <= l_d;
    end
  end

  assign fc.q_pulse   = q_q;
  assign fc.l_pulse   = l_q;
  assign fc.frame_irq = irq_q;

endmodule
